// File: rtl/hardwired_control_unit.sv
// Hardwired T-state sequencer driving the cpu_phase2 control strobes.
// Define SINGLE_STEP_EN to add a step input and park in PAUSE after each instruction.
`timescale 1ns/1ps
module hardwired_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [4:0]  OPC_BR   = 5'b10010,
  parameter logic [4:0]  OPC_JR   = 5'b10011,
  parameter logic [4:0]  OPC_JAL  = 5'b10100,
  parameter logic [4:0]  OPC_NOP  = 5'b11001,
  parameter logic [4:0]  OPC_HALT = 5'b11010
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        PCout,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        r15_sel,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        fault,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_T0     = 4'd0,
    S_T1     = 4'd1,
    S_T2     = 4'd2,
    S_T3     = 4'd3,
    S_T4     = 4'd4,
    S_T5     = 4'd5,
    S_T6     = 4'd6,
    S_HALTED = 4'd8,
    S_FAULT  = 4'd9,
    S_PAUSE  = 4'd10
  } state_e;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0] ALU_ADD = 5'b00011;

`ifdef SINGLE_STEP_EN
  localparam state_e S_DONE = S_PAUSE;
`else
  localparam state_e S_DONE = S_T0;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [4:0] opc;
  logic       is_br, is_jr, is_jal, is_halt;
  logic       ir_unused;

  assign opc       = ir[31:27];
  assign is_br     = (opc == OPC_BR);
  assign is_jr     = (opc == OPC_JR);
  assign is_jal    = (opc == OPC_JAL);
  assign is_halt   = (opc == OPC_HALT);
  assign ir_unused = ^{ir[26:0], OPC_NOP};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_T0: state_d = S_T1;
      S_T1: begin
        if (mem_ready) begin
          state_d = S_T2;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        unique case (1'b1)
          is_br:   state_d = S_T4;
          is_jal:  state_d = S_T4;
          is_halt: state_d = S_HALTED;
          default: state_d = S_DONE;
        endcase
      end
      S_T4: state_d = is_br ? S_T5 : S_DONE;
      S_T5: state_d = S_T6;
      S_T6: state_d = S_DONE;
      S_HALTED: state_d = S_HALTED;
      S_FAULT:  state_d = S_FAULT;
`ifdef SINGLE_STEP_EN
      S_PAUSE: state_d = step ? S_T0 : S_PAUSE;
`else
      S_PAUSE: state_d = S_T0;
`endif
      default: state_d = S_T0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_T0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // clr gates every strobe so an abort never leaks T0 decode
  always_comb begin
    PCout     = 1'b0;
    ZLowOut   = 1'b0;
    ZHighOut  = 1'b0;
    MDRout    = 1'b0;
    Cout      = 1'b0;
    BAout     = 1'b0;
    PCin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    CONin     = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    r15_sel   = 1'b0;
    alu_op    = 5'b00000;
    run       = 1'b1;
    fault     = 1'b0;
    state_dbg = 4'd0;
    if (!clr) begin
      state_dbg = state_q;
      case (state_q)
        S_T0: begin
          PCout = 1'b1;
          MARin = 1'b1;
          IncPC = 1'b1;
          Zin   = 1'b1;
        end
        S_T1: begin
          ZLowOut = 1'b1;
          Read    = 1'b1;
          MDRin   = 1'b1;
          PCin    = (cnt_q == '0);
        end
        S_T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        S_T3: begin
          unique case (1'b1)
            is_br: begin
              Gra   = 1'b1;
              Rout  = 1'b1;
              CONin = 1'b1;
            end
            is_jr: begin
              Gra  = 1'b1;
              Rout = 1'b1;
              PCin = 1'b1;
            end
            is_jal: begin
              PCout   = 1'b1;
              r15_sel = 1'b1;
              Rin     = 1'b1;
            end
            default: ;
          endcase
        end
        S_T4: begin
          if (is_br) begin
            PCout = 1'b1;
            Yin   = 1'b1;
          end else if (is_jal) begin
            Gra  = 1'b1;
            Rout = 1'b1;
            PCin = 1'b1;
          end
        end
        S_T5: begin
          Cout   = 1'b1;
          Zin    = 1'b1;
          alu_op = ALU_ADD;
        end
        S_T6: begin
          ZLowOut = con;
          PCin    = con;
        end
        S_HALTED: run = 1'b0;
        S_FAULT: begin
          run   = 1'b0;
          fault = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
